// File: rtl/instruction_stream_sequencer_pkg.sv
// Shared definitions for the instruction stream sequencer.
//   seq_state_t      : sequencer FSM state encoding
//   NOP_INSTRUCTION  : word driven to the CPU whenever no instruction is valid
//   DEFAULT_* widths : default widths shared by the sequencer and its users
package sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_CHECK   = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_DONE    = 3'd4
   } seq_state_t;

   localparam int NOP_INSTRUCTION = 0;

   localparam int DEFAULT_INSTRUCTION_WIDTH = 32;
   localparam int DEFAULT_PROGRAM_DEPTH     = 1024;
   localparam int DEFAULT_DATA_WIDTH        = 8;
   localparam int DEFAULT_LOOP_WIDTH        = 8;
   localparam int DEFAULT_CHECKSUM_WIDTH    = 16;

endpackage

// File: rtl/instruction_stream_sequencer_program_memory.sv
// program_memory: single-write, single-read synchronous RAM holding the program.
//   clk     : clock, rising edge
//   wr_en   : write wr_data to wr_addr this cycle
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address, sampled every cycle
//   rd_data : mem[rd_addr] one cycle later (old data on same-cycle write)
// Contents are never cleared by reset.
module program_memory #(
   parameter int DEPTH  = 1024,
   parameter int WIDTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/instruction_stream_sequencer.sv
// instruction_stream_sequencer: streams a loaded program into the CPU one
// instruction per issue slot, with per-instruction hold time, stall, multi-pass
// looping, abort and a running checksum of the CPU result.
//   clock_in / reset_n_in        : clock, synchronous active-low reset
//   load_valid/address/data_in   : program write port (honoured in IDLE/DONE only)
//   start_in / abort_in          : begin a run / cancel a run in progress
//   loop_count_in                : passes per run (0 means 1), sampled on start
//   stall_in                     : hold the current instruction
//   cpu_output_in                : signed CPU result, sampled at retire
//   current_instruction_out      : instruction to the CPU, NOP when not valid
//   instruction_valid_out        : high in EXECUTE
//   instruction_index_out        : program counter
//   pass_index_out               : completed passes in this run
//   busy_out / done_out          : run in progress / sticky run complete
//   last_output_out              : CPU result at the most recent retire
//   checksum_out                 : wrapping sum of sign-extended retired results
module instruction_stream_sequencer
   import sequencer_pkg::*;
#(
   parameter int INSTRUCTION_WIDTH      = 32,
   parameter int PROGRAM_DEPTH          = 1024,
   parameter int MAX_INSTRUCTIONS       = 100,
   parameter int CYCLES_PER_INSTRUCTION = 1,
   parameter int DATA_WIDTH             = 8,
   parameter int LOOP_WIDTH             = 8,
   parameter int CHECKSUM_WIDTH         = 16
) (
   input  logic                             clock_in,
   input  logic                             reset_n_in,
   input  logic                             load_valid_in,
   input  logic [$clog2(PROGRAM_DEPTH)-1:0] load_address_in,
   input  logic [INSTRUCTION_WIDTH-1:0]     load_data_in,
   input  logic                             start_in,
   input  logic                             abort_in,
   input  logic [LOOP_WIDTH-1:0]            loop_count_in,
   input  logic                             stall_in,
   input  logic [DATA_WIDTH-1:0]            cpu_output_in,
   output logic [INSTRUCTION_WIDTH-1:0]     current_instruction_out,
   output logic                             instruction_valid_out,
   output logic [$clog2(PROGRAM_DEPTH)-1:0] instruction_index_out,
   output logic [LOOP_WIDTH-1:0]            pass_index_out,
   output logic                             busy_out,
   output logic                             done_out,
   output logic [DATA_WIDTH-1:0]            last_output_out,
   output logic [CHECKSUM_WIDTH-1:0]        checksum_out
);

   localparam int ADDR_W = $clog2(PROGRAM_DEPTH);
   // One spare bit so the pc can reach MAX_INSTRUCTIONS == PROGRAM_DEPTH.
   localparam int PC_W   = ADDR_W + 1;
   localparam int HOLD_W = (CYCLES_PER_INSTRUCTION > 1) ? $clog2(CYCLES_PER_INSTRUCTION) : 1;

   function automatic logic signed [CHECKSUM_WIDTH-1:0] sign_extend(
      input logic signed [DATA_WIDTH-1:0] value
   );
      return CHECKSUM_WIDTH'(value);
   endfunction

   seq_state_t                     state_q;
   logic [PC_W-1:0]                pc_q;
   logic [LOOP_WIDTH-1:0]          pass_q;
   logic [LOOP_WIDTH-1:0]          loops_q;
   logic [HOLD_W-1:0]              hold_q;
   logic [INSTRUCTION_WIDTH-1:0]   instr_q;
   logic                           done_q;
   logic [DATA_WIDTH-1:0]          last_q;
   logic [CHECKSUM_WIDTH-1:0]      csum_q;
   logic [INSTRUCTION_WIDTH-1:0]   rd_word;
   logic                           mem_wr_en;
   logic                           end_of_pass;
   logic [LOOP_WIDTH-1:0]          pass_next;
   logic signed [DATA_WIDTH-1:0]   cpu_result;

   // Loads are only safe while no run is reading the memory.
   assign mem_wr_en = load_valid_in && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   program_memory #(
      .DEPTH (PROGRAM_DEPTH),
      .WIDTH (INSTRUCTION_WIDTH),
      .ADDR_W(ADDR_W)
   ) u_program_memory (
      .clk    (clock_in),
      .wr_en  (mem_wr_en),
      .wr_addr(load_address_in),
      .wr_data(load_data_in),
      .rd_addr(pc_q[ADDR_W-1:0]),
      .rd_data(rd_word)
   );

   assign end_of_pass = (rd_word == INSTRUCTION_WIDTH'(NOP_INSTRUCTION)) ||
                        (pc_q == PC_W'(MAX_INSTRUCTIONS));
   assign pass_next   = pass_q + 1'b1;
   assign cpu_result  = $signed(cpu_output_in);

   always_ff @(posedge clock_in) begin
      if (!reset_n_in) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         pass_q  <= '0;
         loops_q <= '0;
         hold_q  <= '0;
         instr_q <= '0;
         done_q  <= 1'b0;
         last_q  <= '0;
         csum_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_in) begin
                  pc_q    <= '0;
                  pass_q  <= '0;
                  csum_q  <= '0;
                  last_q  <= '0;
                  done_q  <= 1'b0;
                  loops_q <= (loop_count_in == '0) ? LOOP_WIDTH'(1) : loop_count_in;
                  state_q <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               state_q <= abort_in ? ST_IDLE : ST_CHECK;
            end
            ST_CHECK: begin
               if (abort_in) begin
                  state_q <= ST_IDLE;
               end else if (end_of_pass) begin
                  pass_q <= pass_next;
                  if (pass_next < loops_q) begin
                     pc_q    <= '0;
                     state_q <= ST_FETCH;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end else begin
                  instr_q <= rd_word;
                  hold_q  <= HOLD_W'(CYCLES_PER_INSTRUCTION - 1);
                  state_q <= ST_EXECUTE;
               end
            end
            ST_EXECUTE: begin
               // Abort wins over a retire in the same cycle.
               if (abort_in) begin
                  instr_q <= INSTRUCTION_WIDTH'(NOP_INSTRUCTION);
                  state_q <= ST_IDLE;
               end else if (!stall_in) begin
                  if (hold_q != '0) begin
                     hold_q <= hold_q - 1'b1;
                  end else begin
                     last_q  <= cpu_output_in;
                     csum_q  <= csum_q + $unsigned(sign_extend(cpu_result));
                     pc_q    <= pc_q + 1'b1;
                     instr_q <= INSTRUCTION_WIDTH'(NOP_INSTRUCTION);
                     state_q <= ST_FETCH;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign current_instruction_out = instr_q;
   assign instruction_valid_out   = (state_q == ST_EXECUTE);
   assign instruction_index_out   = pc_q[ADDR_W-1:0];
   assign pass_index_out          = pass_q;
   assign busy_out                = (state_q == ST_FETCH) || (state_q == ST_CHECK) ||
                                    (state_q == ST_EXECUTE);
   assign done_out                = done_q;
   assign last_output_out         = last_q;
   assign checksum_out            = csum_q;

endmodule

// File: tb/tb_instruction_stream_sequencer.sv
// Directed bench for instruction_stream_sequencer. Two instances share every
// input: u_seq1 with one cycle per instruction and u_seq3 with three.
module tb_instruction_stream_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_valid = 1'b0;
   logic [9:0]  load_addr = '0;
   logic [31:0] load_data = '0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  loop_count = '0;
   logic        stall = 1'b0;
   logic [7:0]  cpu_out = '0;

   logic [31:0] i1, i3;
   logic        v1, v3, b1, b3, d1, d3;
   logic [9:0]  x1, x3;
   logic [7:0]  p1, p3, l1, l3;
   logic [15:0] c1, c3;

   int tests = 0;
   int fails = 0;
   // Observed instruction order and retire counts per instance.
   logic [31:0] s1 [4];
   logic [31:0] s3 [4];
   int r1, r3, c22;
   logic pv1 = 1'b0, pv3 = 1'b0;

   always #5 clk = ~clk;

   instruction_stream_sequencer #(.CYCLES_PER_INSTRUCTION(1)) u_seq1 (
      .clock_in(clk), .reset_n_in(rst_n), .load_valid_in(load_valid),
      .load_address_in(load_addr), .load_data_in(load_data), .start_in(start),
      .abort_in(abort), .loop_count_in(loop_count), .stall_in(stall),
      .cpu_output_in(cpu_out), .current_instruction_out(i1),
      .instruction_valid_out(v1), .instruction_index_out(x1), .pass_index_out(p1),
      .busy_out(b1), .done_out(d1), .last_output_out(l1), .checksum_out(c1));

   instruction_stream_sequencer #(.CYCLES_PER_INSTRUCTION(3)) u_seq3 (
      .clock_in(clk), .reset_n_in(rst_n), .load_valid_in(load_valid),
      .load_address_in(load_addr), .load_data_in(load_data), .start_in(start),
      .abort_in(abort), .loop_count_in(loop_count), .stall_in(stall),
      .cpu_output_in(cpu_out), .current_instruction_out(i3),
      .instruction_valid_out(v3), .instruction_index_out(x3), .pass_index_out(p3),
      .busy_out(b3), .done_out(d3), .last_output_out(l3), .checksum_out(c3));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, sample 1 ns later, log newly valid instructions.
   task automatic tick();
      @(posedge clk);
      #1;
      if (v1 && !pv1) begin
         if (r1 < 4) s1[r1] = i1;
         r1++;
      end
      if (v3 && !pv3) begin
         if (r3 < 4) s3[r3] = i3;
         r3++;
      end
      if (v3 && i3 == 32'h22) c22++;
      pv1 = v1;
      pv3 = v3;
   endtask

   task automatic load(input logic [9:0] a, input logic [31:0] d);
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = d;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic start_run(input logic [7:0] lc, input logic [7:0] co);
      r1 = 0; r3 = 0; c22 = 0;
      for (int k = 0; k < 4; k++) begin
         s1[k] = '0;
         s3[k] = '0;
      end
      loop_count = lc;
      cpu_out    = co;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (!(d1 && d3) && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_done_in_budget"}, 64'(d1 && d3), 64'd1);
   endtask

   task automatic load_basic();
      load(10'd0, 32'h11);
      load(10'd1, 32'h22);
      load(10'd2, 32'h33);
      load(10'd3, 32'h0);
   endtask

   initial begin
      int k, fv, n, stall_left;
      bit stall_started;

      // Reset state
      tick(); tick();
      check("rst_instr", 64'(i1), 64'd0);
      check("rst_valid", 64'(v1), 64'd0);
      check("rst_index", 64'(x1), 64'd0);
      check("rst_pass", 64'(p1), 64'd0);
      check("rst_busy", 64'(b1), 64'd0);
      check("rst_done", 64'(d1), 64'd0);
      check("rst_last", 64'(l1), 64'd0);
      check("rst_csum", 64'(c1), 64'd0);
      rst_n = 1'b1;
      tick();

      // Basic program, one cycle per instruction
      load_basic();
      start_run(8'd1, 8'd5);
      k = 1; fv = 0;
      check("t1_busy_after_start", 64'(b1), 64'd1);
      check("t1_valid_after_start", 64'(v1), 64'd0);
      while (!d1 && k < 60) begin
         tick();
         k++;
         if (v1 && fv == 0) fv = k;
      end
      check("t1_first_valid_edge", 64'(fv), 64'd3);
      check("t1_done_edge", 64'(k), 64'd12);
      check("t1_retires", 64'(r1), 64'd3);
      check("t1_seq0", 64'(s1[0]), 64'h11);
      check("t1_seq1", 64'(s1[1]), 64'h22);
      check("t1_seq2", 64'(s1[2]), 64'h33);
      check("t1_csum", 64'(c1), 64'd15);
      check("t1_last", 64'(l1), 64'd5);
      check("t1_pass", 64'(p1), 64'd1);
      check("t1_busy_done", 64'(b1), 64'd0);
      check("t1_instr_nop", 64'(i1), 64'd0);
      wait_done(100, "t1");
      check("t1_csum3", 64'(c3), 64'd15);

      // CPI=3 with a 4-cycle stall on the second instruction
      start_run(8'd1, 8'd5);
      n = 0; stall_left = 0; stall_started = 0;
      while (!d3 && n < 200) begin
         tick();
         n++;
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) stall = 1'b0;
         end
         if (c22 == 1 && !stall_started) begin
            stall = 1'b1;
            stall_left = 4;
            stall_started = 1;
         end
      end
      stall = 1'b0;
      check("t2_hold_cycles_22", 64'(c22), 64'd7);
      check("t2_retires", 64'(r3), 64'd3);
      check("t2_seq0", 64'(s3[0]), 64'h11);
      check("t2_seq1", 64'(s3[1]), 64'h22);
      check("t2_seq2", 64'(s3[2]), 64'h33);
      check("t2_csum", 64'(c3), 64'd15);
      wait_done(100, "t2");

      // Three passes with a result of -1
      start_run(8'd3, 8'hFF);
      wait_done(300, "t3");
      check("t3_retires", 64'(r1), 64'd9);
      check("t3_pass", 64'(p1), 64'd3);
      check("t3_csum", 64'(c1), 64'hFFF7);
      check("t3_last", 64'(l1), 64'hFF);
      check("t3_csum3", 64'(c3), 64'hFFF7);
      check("t3_last3", 64'(l3), 64'hFF);
      check("t3_pass3", 64'(p3), 64'd3);

      // 150 nonzero words, pass ends at MAX_INSTRUCTIONS
      for (int a = 0; a < 150; a++) load(10'(a), 32'h100 + 32'(a));
      start_run(8'd1, 8'd1);
      wait_done(1500, "t4");
      check("t4_retires", 64'(r1), 64'd100);
      check("t4_index", 64'(x1), 64'd100);
      check("t4_csum", 64'(c1), 64'd100);
      check("t4_index3", 64'(x3), 64'd100);

      // Abort during the second EXECUTE, with an ignored load
      load_basic();
      start_run(8'd1, 8'd7);
      n = 0;
      while (!(v1 && i1 == 32'h22) && n < 20) begin
         tick();
         n++;
      end
      check("t5_reached_second", 64'(v1 && i1 == 32'h22), 64'd1);
      abort = 1'b1;
      cpu_out = 8'd9;
      load_valid = 1'b1;
      load_addr = 10'd1;
      load_data = 32'hBAD;
      tick();
      abort = 1'b0;
      load_valid = 1'b0;
      check("t5_busy", 64'(b1), 64'd0);
      check("t5_valid", 64'(v1), 64'd0);
      check("t5_instr", 64'(i1), 64'd0);
      check("t5_done", 64'(d1), 64'd0);
      check("t5_csum", 64'(c1), 64'd7);
      check("t5_last", 64'(l1), 64'd7);
      check("t5_csum3", 64'(c3), 64'd7);
      check("t5_busy3", 64'(b3), 64'd0);
      start_run(8'd1, 8'd7);
      wait_done(200, "t5_rerun");
      check("t5_mem_word1", 64'(s1[1]), 64'h22);
      check("t5_mem_word1_3", 64'(s3[1]), 64'h22);
      check("t5_rerun_csum", 64'(c1), 64'd21);

      // Reset during EXECUTE, then restart without reload
      start_run(8'd1, 8'd5);
      n = 0;
      while (!v1 && n < 10) begin
         tick();
         n++;
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t6_instr", 64'(i1), 64'd0);
      check("t6_valid", 64'(v1), 64'd0);
      check("t6_index", 64'(x1), 64'd0);
      check("t6_pass", 64'(p1), 64'd0);
      check("t6_busy", 64'(b1), 64'd0);
      check("t6_last", 64'(l1), 64'd0);
      check("t6_csum", 64'(c1), 64'd0);
      check("t6_busy3", 64'(b3), 64'd0);
      start_run(8'd1, 8'd5);
      wait_done(200, "t6_restart");
      check("t6_seq0", 64'(s1[0]), 64'h11);
      check("t6_seq2", 64'(s1[2]), 64'h33);
      check("t6_csum_restart", 64'(c1), 64'd15);

      // Empty program, loop count 2
      load(10'd0, 32'h0);
      start_run(8'd2, 8'd5);
      wait_done(100, "t7");
      check("t7_retires", 64'(r1), 64'd0);
      check("t7_pass", 64'(p1), 64'd2);
      check("t7_csum", 64'(c1), 64'd0);
      check("t7_pass3", 64'(p3), 64'd2);

      // Loop count 0 behaves as a single pass
      start_run(8'd0, 8'd5);
      wait_done(100, "t8");
      check("t8_pass", 64'(p1), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
